// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_EXR  = 4'd2,
        S_EXI  = 4'd3,
        S_ADDR = 4'd4,
        S_MRD  = 4'd5,
        S_MWR  = 4'd6,
        S_WBR  = 4'd7,
        S_WBI  = 4'd8,
        S_WBM  = 4'd9,
        S_BEQ  = 4'd10,
        S_JMP  = 4'd11,
        S_JAL  = 4'd12,
        S_ERR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // True for the R-type function codes the datapath implements
    function automatic logic isRFunct(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - ALU operation select from controller state and IR fields
module mc_alu_dec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] ALUctr
);

    // Add everywhere except R-type execute, ORI execute and the branch compare
    always_comb begin
        ALUctr = ALU_ADD;
        case (state)
            S_EXR: begin
                case (funct)
                    FN_SUB:  ALUctr = ALU_SUB;
                    FN_AND:  ALUctr = ALU_AND;
                    FN_OR:   ALUctr = ALU_OR;
                    FN_SLT:  ALUctr = ALU_SLT;
                    default: ALUctr = ALU_ADD;
                endcase
            end
            S_EXI:   if (op == OP_ORI) ALUctr = ALU_OR;
            S_BEQ:   ALUctr = ALU_SUB;
            default: ALUctr = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle CPU controller FSM; JAL support under MC_CTRL_JAL_EN
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IorD,
    output logic       RegWr,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ExtOp,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [2:0] ALUctr,
    output logic [1:0] PCsrc,
    output logic       Link,
    output logic [3:0] state,
    output logic [1:0] err
);

    state_t           cur;
    state_t           nxt;
    state_t           idNext;
    logic [CNT_W-1:0] waitCnt;
    logic [1:0]       errReg;
    logic             memState;
    logic             timeout;

    assign memState = (cur == S_IF) || (cur == S_MRD) || (cur == S_MWR);
    assign timeout  = memState && !mem_ready && (waitCnt == CNT_W'(WAIT_MAX));
    assign state    = cur;
    assign err      = errReg;

    mc_alu_dec u_alu_dec (
        .state  (cur),
        .op     (op),
        .funct  (funct),
        .ALUctr (ALUctr)
    );

    // Instruction class decode used when leaving ID
    always_comb begin
        idNext = S_ERR;
        case (op)
            OP_RTYPE:         idNext = isRFunct(funct) ? S_EXR : S_ERR;
            OP_ORI, OP_ADDIU: idNext = S_EXI;
            OP_LW, OP_SW:     idNext = S_ADDR;
            OP_BEQ:           idNext = S_BEQ;
            OP_J:             idNext = S_JMP;
`ifdef MC_CTRL_JAL_EN
            OP_JAL:           idNext = S_JAL;
`endif
            default:          idNext = S_ERR;
        endcase
    end

    // Next state; a completing memory access takes priority over the timeout
    always_comb begin
        nxt = cur;
        case (cur)
            S_IF:   if (mem_ready) nxt = S_ID;  else if (timeout) nxt = S_ERR;
            S_ID:   nxt = idNext;
            S_EXR:  nxt = S_WBR;
            S_EXI:  nxt = S_WBI;
            S_ADDR: nxt = (op == OP_SW) ? S_MWR : S_MRD;
            S_MRD:  if (mem_ready) nxt = S_WBM; else if (timeout) nxt = S_ERR;
            S_MWR:  if (mem_ready) nxt = S_IF;  else if (timeout) nxt = S_ERR;
            S_WBR, S_WBI, S_WBM, S_BEQ, S_JMP: nxt = S_IF;
`ifdef MC_CTRL_JAL_EN
            S_JAL:  nxt = S_IF;
`endif
            S_ERR:  nxt = S_ERR;
            default: nxt = S_IF;
        endcase
    end

    // State, wait counter and sticky error code; err only changes on entry to ERR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur     <= S_IF;
            waitCnt <= '0;
            errReg  <= ERR_NONE;
        end else begin
            cur <= nxt;
            if (nxt == S_ERR && cur != S_ERR)
                errReg <= timeout ? ERR_TIMEOUT : ERR_ILLEGAL;
            if (memState && !mem_ready && nxt == cur)
                waitCnt <= waitCnt + 1'b1;
            else
                waitCnt <= '0;
        end
    end

    // Datapath strobes decoded from state; all forced low while reset is asserted
    always_comb begin
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        IorD     = 1'b0;
        RegWr    = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ExtOp    = 1'b0;
        ALUsrcA  = 1'b0;
        Link     = 1'b0;
        ALUsrcB  = SRCB_REG;
        PCsrc    = PCSRC_ALU;
        case (cur)
            S_IF: begin
                MemRd   = ~timeout;
                ALUsrcB = SRCB_FOUR;
                IRWr    = mem_ready;
                PCWr    = mem_ready;
            end
            S_ID: begin
                ALUsrcB = SRCB_IMMSH;
                ExtOp   = 1'b1;
            end
            S_EXR: ALUsrcA = 1'b1;
            S_EXI: begin
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_IMM;
                ExtOp   = (op != OP_ORI);
            end
            S_ADDR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = SRCB_IMM;
                ExtOp   = 1'b1;
            end
            S_MRD: begin
                MemRd = ~timeout;
                IorD  = 1'b1;
            end
            S_MWR: begin
                MemWr = ~timeout;
                IorD  = 1'b1;
            end
            S_WBR: begin
                RegWr  = 1'b1;
                RegDst = 1'b1;
            end
            S_WBI: RegWr = 1'b1;
            S_WBM: begin
                RegWr    = 1'b1;
                MemtoReg = 1'b1;
            end
            S_BEQ: begin
                ALUsrcA = 1'b1;
                PCsrc   = PCSRC_BR;
                PCWr    = zero;
            end
            S_JMP: begin
                PCsrc = PCSRC_JMP;
                PCWr  = 1'b1;
            end
`ifdef MC_CTRL_JAL_EN
            S_JAL: begin
                PCsrc = PCSRC_JMP;
                PCWr  = 1'b1;
                RegWr = 1'b1;
                Link  = 1'b1;
            end
`endif
            default: ;
        endcase
        if (!rst_n) begin
            PCWr  = 1'b0;
            IRWr  = 1'b0;
            MemRd = 1'b0;
            MemWr = 1'b0;
            RegWr = 1'b0;
            Link  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl (honours MC_CTRL_JAL_EN)
module tb_mc_ctrl;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWr, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, MemtoReg, ExtOp, ALUsrcA, Link;
    logic [1:0] ALUsrcB, PCsrc, err;
    logic [2:0] ALUctr;
    logic [3:0] state;

    int nChecks = 0;
    int nPass = 0;
    int modelErr = 0;
    int errHold = 20;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         lowState;
        int         lowCount;
        int         cycles;
        logic [3:0] lastSt;
        logic [2:0] alu;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr), .IorD(IorD), .RegWr(RegWr),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ExtOp(ExtOp), .ALUsrcA(ALUsrcA),
        .ALUsrcB(ALUsrcB), .ALUctr(ALUctr), .PCsrc(PCsrc), .Link(Link), .state(state), .err(err)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [17:0] outVec();
        return {PCWr, IRWr, MemRd, MemWr, IorD, RegWr, RegDst, MemtoReg, ExtOp, ALUsrcA,
                ALUsrcB, ALUctr, PCsrc, Link};
    endfunction

    // Required outputs for a state, straight from the per-state strobe lists
    function automatic logic [17:0] expVec(input int st, input logic [5:0] o, input logic [5:0] f,
                                           input logic z, input logic mr, input logic tmo);
        logic pcwr = 0, irwr = 0, memrd = 0, memwr = 0, iord = 0, regwr = 0;
        logic regdst = 0, m2r = 0, ext = 0, srca = 0, link = 0;
        logic [1:0] srcb = 0, pcsrc = 0;
        logic [2:0] alu = 0;
        case (st)
            0:  begin memrd = !tmo; srcb = 2'b01; irwr = mr; pcwr = mr; end
            1:  begin srcb = 2'b11; ext = 1; end
            2:  begin
                    srca = 1;
                    alu = (f == 34) ? 3'd1 : (f == 36) ? 3'd2 : (f == 37) ? 3'd3 : (f == 42) ? 3'd4 : 3'd0;
                end
            3:  begin srca = 1; srcb = 2'b10; if (o == 6'b001101) alu = 3'd3; else ext = 1; end
            4:  begin srca = 1; srcb = 2'b10; ext = 1; end
            5:  begin memrd = !tmo; iord = 1; end
            6:  begin memwr = !tmo; iord = 1; end
            7:  begin regwr = 1; regdst = 1; end
            8:  regwr = 1;
            9:  begin regwr = 1; m2r = 1; end
            10: begin srca = 1; alu = 3'd1; pcsrc = 2'b01; pcwr = z; end
            11: begin pcsrc = 2'b10; pcwr = 1; end
            12: begin pcsrc = 2'b10; pcwr = 1; regwr = 1; link = 1; end
            default: ;
        endcase
        return {pcwr, irwr, memrd, memwr, iord, regwr, regdst, m2r, ext, srca, srcb, alu, pcsrc, link};
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'($urandom_range(1));
        #1;
        check("reset_strobes", {PCWr, IRWr, MemWr, RegWr, MemRd}, 5'b0);
        modelErr = 0;
    endtask

    task automatic stepState(input logic [3:0] s);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("step_state", state, s);
    endtask

    // Runs one instruction from IF; phase list built from the instruction class
    task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic z, input bit rnd,
                            input int lowState, input int lowCount,
                            output int nCyc, output logic [3:0] lastSt, output logic [2:0] execAlu);
        int q[$];
        int idx, waits, lowLeft, st, pendErr;
        logic mr, tmo;
        q = {0, 1};
        pendErr = 0;
        case (o)
            6'h00: begin
                if (f == 32 || f == 34 || f == 36 || f == 37 || f == 42) begin q.push_back(2); q.push_back(7); end
                else begin q.push_back(15); pendErr = 1; end
            end
            6'h0d, 6'h09: begin q.push_back(3); q.push_back(8); end
            6'h23: begin q.push_back(4); q.push_back(5); q.push_back(9); end
            6'h2b: begin q.push_back(4); q.push_back(6); end
            6'h04: q.push_back(10);
            6'h02: q.push_back(11);
`ifdef MC_CTRL_JAL_EN
            6'h03: q.push_back(12);
`endif
            default: begin q.push_back(15); pendErr = 1; end
        endcase
        idx = 0; waits = 0; lowLeft = lowCount; nCyc = 0; execAlu = 0; lastSt = 0;
        while (idx < q.size()) begin
            st = q[idx];
            @(negedge clk);
            rst_n = 1'b1; op = o; funct = f; zero = z;
            if (st == lowState && lowLeft > 0) begin mr = 0; lowLeft--; end
            else if (rnd) mr = ($urandom_range(3) != 0);
            else mr = 1;
            mem_ready = mr;
            #1;
            nCyc++;
            lastSt = 4'(st);
            if (st == 15) modelErr = pendErr;
            tmo = (st == 0 || st == 5 || st == 6) && !mr && (waits == WAIT_MAX);
            check("state", state, 32'(st));
            check("err", err, 32'(modelErr));
            check("outputs", outVec(), expVec(st, o, f, z, mr, tmo));
            if (st == 2 || st == 3 || st == 4 || st == 10) execAlu = ALUctr;
            if (st == 15) begin
                for (int k = 0; k < errHold; k++) begin
                    @(negedge clk);
                    mem_ready = 1'($urandom_range(1));
                    zero = 1'($urandom_range(1));
                    #1;
                    check("err_hold_state", state, 15);
                    check("err_hold_err", err, 32'(modelErr));
                    check("err_hold_strobes", outVec(), 0);
                end
                doReset();
                break;
            end
            if (st == 0 || st == 5 || st == 6) begin
                if (mr) begin idx++; waits = 0; end
                else if (tmo) begin q.insert(idx + 1, 15); pendErr = 2; idx++; end
                else waits++;
            end else begin
                idx++;
            end
        end
    endtask

    initial begin
        int nc;
        logic [3:0] ls;
        logic [2:0] ea;
        logic [5:0] ro, rf;
        int pick;

        vecs.push_back('{6'h00, 6'd32, 1'b0, -1, 0, 4, 4'd7, 3'd0});
        vecs.push_back('{6'h00, 6'd34, 1'b0, -1, 0, 4, 4'd7, 3'd1});
        vecs.push_back('{6'h00, 6'd36, 1'b0, -1, 0, 4, 4'd7, 3'd2});
        vecs.push_back('{6'h00, 6'd37, 1'b0, -1, 0, 4, 4'd7, 3'd3});
        vecs.push_back('{6'h00, 6'd42, 1'b0, -1, 0, 4, 4'd7, 3'd4});
        vecs.push_back('{6'h0d, 6'd0,  1'b0, -1, 0, 4, 4'd8, 3'd3});
        vecs.push_back('{6'h09, 6'd0,  1'b0, -1, 0, 4, 4'd8, 3'd0});
        vecs.push_back('{6'h23, 6'd0,  1'b0, -1, 0, 5, 4'd9, 3'd0});
        vecs.push_back('{6'h2b, 6'd0,  1'b0, -1, 0, 4, 4'd6, 3'd0});
        vecs.push_back('{6'h04, 6'd0,  1'b1, -1, 0, 3, 4'd10, 3'd1});
        vecs.push_back('{6'h04, 6'd0,  1'b0, -1, 0, 3, 4'd10, 3'd1});
        vecs.push_back('{6'h02, 6'd0,  1'b0, -1, 0, 3, 4'd11, 3'd0});
        vecs.push_back('{6'h23, 6'd0,  1'b0,  5, 3, 8, 4'd9, 3'd0});
        vecs.push_back('{6'h3f, 6'd0,  1'b0, -1, 0, 3, 4'd15, 3'd0});
        vecs.push_back('{6'h00, 6'd33, 1'b0, -1, 0, 3, 4'd15, 3'd0});
        vecs.push_back('{6'h00, 6'd32, 1'b0,  0, 16, 17, 4'd15, 3'd0});
        vecs.push_back('{6'h00, 6'd32, 1'b0,  0, 15, 19, 4'd7, 3'd0});
        vecs.push_back('{6'h23, 6'd0,  1'b0,  5, 16, 20, 4'd15, 3'd0});
        vecs.push_back('{6'h2b, 6'd0,  1'b0,  6, 16, 20, 4'd15, 3'd0});
`ifdef MC_CTRL_JAL_EN
        vecs.push_back('{6'h03, 6'd0,  1'b0, -1, 0, 3, 4'd12, 3'd0});
`else
        vecs.push_back('{6'h03, 6'd0,  1'b0, -1, 0, 3, 4'd15, 3'd0});
`endif

        doReset();

        foreach (vecs[i]) begin
            runInstr(vecs[i].op, vecs[i].funct, vecs[i].zero, 1'b0, vecs[i].lowState, vecs[i].lowCount,
                     nc, ls, ea);
            check($sformatf("vec%0d_cycles", i), nc, vecs[i].cycles);
            check($sformatf("vec%0d_last", i), ls, vecs[i].lastSt);
            check($sformatf("vec%0d_alu", i), ea, vecs[i].alu);
        end

        // reset during write-back of an add must suppress RegWr
        op = 6'h00; funct = 6'd32; zero = 1'b0;
        stepState(4'd0); stepState(4'd1); stepState(4'd2);
        @(negedge clk); rst_n = 1'b0; mem_ready = 1'b1; #1;
        check("rst_wbr_state", state, 7);
        check("rst_wbr_regwr", RegWr, 0);
        modelErr = 0;

        // reset during a store must suppress MemWr
        op = 6'h2b;
        stepState(4'd0); stepState(4'd1); stepState(4'd4);
        @(negedge clk); rst_n = 1'b0; mem_ready = 1'b1; #1;
        check("rst_mwr_state", state, 6);
        check("rst_mwr_memwr", {MemWr, PCWr, RegWr}, 0);
        modelErr = 0;

        errHold = 4;
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 11);
            rf = 6'($urandom_range(63));
            case (pick)
                0: begin ro = 6'h00; rf = 6'd32; end
                1: begin ro = 6'h00; rf = 6'd34; end
                2: begin ro = 6'h00; rf = 6'd36; end
                3: begin ro = 6'h00; rf = 6'd37; end
                4: begin ro = 6'h00; rf = 6'd42; end
                5: ro = 6'h0d;
                6: ro = 6'h09;
                7: ro = 6'h23;
                8: ro = 6'h2b;
                9: ro = 6'h04;
                10: ro = 6'h02;
                default: ro = 6'($urandom_range(63));
            endcase
            runInstr(ro, rf, 1'($urandom_range(1)), 1'b1, -1, 0, nc, ls, ea);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
